// File: rtl/scope_frame_serializer_if.sv
// rtl/scope_frame_serializer_if.sv - position input and scope output bundle for scope_frame_serializer
interface scope_frame_serializer_if;
    logic [55:0] pos_x_flat;
    logic [47:0] pos_y_flat;
    logic        pos_valid;
    logic [7:0]  to_scope;
    logic        frame_active;
    logic        frame_done;

    modport master (
        output pos_x_flat,
        output pos_y_flat,
        output pos_valid,
        input  to_scope,
        input  frame_active,
        input  frame_done
    );

    modport slave (
        input  pos_x_flat,
        input  pos_y_flat,
        input  pos_valid,
        output to_scope,
        output frame_active,
        output frame_done
    );
endinterface

// File: rtl/scope_frame_serializer.sv
// rtl/scope_frame_serializer.sv - snapshots 8 object positions and streams sync/X/Y frames to the scope DAC (SCOPE_INDEX_EN adds an index level per object)
module scope_frame_serializer #(
    parameter int DWELL      = 1024,
    parameter int SYNC_DWELL = 4096,
    parameter int FREE_RUN   = 0
) (
    input logic                      clock,
    input logic                      reset,
    scope_frame_serializer_if.slave  bus
);

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
    localparam logic [15:0] SYNC_LAST  = 16'(SYNC_DWELL - 1);
    localparam logic [7:0]  SYNC_LEVEL = 8'h7F;
    localparam logic [7:0]  X_CLAMP    = 8'h7E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
`ifdef SCOPE_INDEX_EN
        ST_IDX,
`endif
        ST_X,
        ST_Y
    } state_t;

`ifdef SCOPE_INDEX_EN
    localparam state_t ST_OBJ_FIRST = ST_IDX;
`else
    localparam state_t ST_OBJ_FIRST = ST_X;
`endif

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  obj_idx_q, obj_idx_d;
    logic        pending_q, pending_d;
    logic        start;

    logic [6:0]  x_snap_q [8];
    logic [5:0]  y_snap_q [8];

    logic [7:0]  to_scope_q, to_scope_d;
    logic        active_q, active_d;
    logic        done_q, done_d;

    logic [6:0]  x_sel;
    logic [5:0]  y_sel;

    // Sequencing: cnt counts cycles already spent in the current level.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        obj_idx_d = obj_idx_q;
        pending_d = pending_q | bus.pos_valid;
        start     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                if (pending_q || (FREE_RUN != 0)) begin
                    start     = 1'b1;
                    state_d   = ST_SYNC;
                    pending_d = bus.pos_valid;
                end
            end
            ST_SYNC: begin
                if (cnt_q == SYNC_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = ST_OBJ_FIRST;
                end
            end
`ifdef SCOPE_INDEX_EN
            ST_IDX: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = ST_X;
                end
            end
`endif
            ST_X: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = ST_Y;
                end
            end
            ST_Y: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d     = 16'd0;
                    obj_idx_d = obj_idx_q + 3'd1;
                    state_d   = (obj_idx_q == 3'd7) ? ST_IDLE : ST_OBJ_FIRST;
                end
            end
            default: begin
                cnt_d   = 16'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state, so the snapshot is
    // always stable by the time an X or Y level is selected from it.
    always_comb begin
        x_sel      = x_snap_q[obj_idx_d];
        y_sel      = y_snap_q[obj_idx_d];
        to_scope_d = 8'h00;

        case (state_d)
            ST_SYNC: to_scope_d = SYNC_LEVEL;
`ifdef SCOPE_INDEX_EN
            ST_IDX:  to_scope_d = {5'b0, obj_idx_d};
`endif
            ST_X:    to_scope_d = (x_sel == 7'd127) ? X_CLAMP : {1'b0, x_sel};
            ST_Y:    to_scope_d = {2'b00, y_sel};
            default: to_scope_d = 8'h00;
        endcase

        active_d = (state_d != ST_IDLE);
        done_d   = (state_d == ST_Y) && (obj_idx_d == 3'd7) && (cnt_d == DWELL_LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            obj_idx_q  <= 3'd0;
            pending_q  <= 1'b0;
            to_scope_q <= 8'h00;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            obj_idx_q  <= obj_idx_d;
            pending_q  <= pending_d;
            to_scope_q <= to_scope_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    // Snapshot is data-only; it needs no reset because it is only read
    // after a frame start has loaded it.
    always_ff @(posedge clock) begin
        if (start && !reset) begin
            for (int i = 0; i < 8; i++) begin
                x_snap_q[i] <= bus.pos_x_flat[7*i +: 7];
                y_snap_q[i] <= bus.pos_y_flat[6*i +: 6];
            end
        end
    end

    assign bus.to_scope     = to_scope_q;
    assign bus.frame_active = active_q;
    assign bus.frame_done   = done_q;

endmodule

// File: tb/tb_scope_frame_serializer.sv
// tb/tb_scope_frame_serializer.sv - scoreboard bench for scope_frame_serializer
module tb_scope_frame_serializer;

`ifdef SCOPE_INDEX_EN
    localparam int SPO = 3;
`else
    localparam int SPO = 2;
`endif
    localparam int DW   = 2;
    localparam int SD   = 3;
    localparam int FLEN = SD + 8 * SPO * DW;
    localparam int RST_POS = SD + 4 * SPO * DW + (SPO - 2) * DW + 1;

    logic clock;
    logic reset;
    scope_frame_serializer_if bus ();

    scope_frame_serializer #(
        .DWELL      (DW),
        .SYNC_DWELL (SD),
        .FREE_RUN   (0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q [$];
    int frame_pos   = 0;
    int idle_run    = 0;
    bit expect_gap1 = 0;
    logic [6:0] cur_x [8];
    logic [5:0] cur_y [8];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] v, input logic d);
        exp_q.push_back({d, v});
    endtask

    task automatic push_frame();
        logic [7:0] xv;
        for (int s = 0; s < SD; s++) push(8'h7F, 1'b0);
        for (int i = 0; i < 8; i++) begin
`ifdef SCOPE_INDEX_EN
            for (int k = 0; k < DW; k++) push(8'(i), 1'b0);
`endif
            xv = (cur_x[i] == 7'd127) ? 8'h7E : {1'b0, cur_x[i]};
            for (int k = 0; k < DW; k++) push(xv, 1'b0);
            for (int k = 0; k < DW; k++) push({2'b00, cur_y[i]}, (i == 7) && (k == DW - 1));
        end
    endtask

    task automatic drive_pos();
        for (int i = 0; i < 8; i++) begin
            bus.pos_x_flat[7*i +: 7] = cur_x[i];
            bus.pos_y_flat[6*i +: 6] = cur_y[i];
        end
    endtask

    task automatic pulse_valid();
        bus.pos_valid = 1'b1;
        @(posedge clock); #1;
        bus.pos_valid = 1'b0;
    endtask

    task automatic apply_and_push();
        drive_pos();
        push_frame();
        pulse_valid();
    endtask

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        while (frame_pos < p && n < 500) begin
            @(posedge clock); #1;
            n++;
        end
        chk("wait_frame_pos_timeout", (n < 500) ? 1 : 0, 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.frame_active) && n < 1000) begin
            @(posedge clock); #1;
            n++;
        end
        chk("drain_timeout", (n < 1000) ? 1 : 0, 1);
    endtask

    always @(negedge clock) begin
        logic [8:0] e;
        if (reset) begin
            frame_pos = 0;
            idle_run  = 0;
        end else if (bus.frame_active) begin
            if (frame_pos == 0 && expect_gap1) begin
                chk("idle_gap", idle_run, 1);
                expect_gap1 = 0;
            end
            idle_run = 0;
            frame_pos++;
            if (exp_q.size() == 0) begin
                chk("unexpected_sample", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("to_scope", bus.to_scope, e[7:0]);
                chk("frame_done", bus.frame_done, e[8]);
            end
            if (bus.frame_done) chk("frame_len", frame_pos, FLEN);
        end else begin
            chk("idle_to_scope", bus.to_scope, 0);
            chk("idle_done", bus.frame_done, 0);
            frame_pos = 0;
            idle_run++;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bus.pos_valid  = 1'b0;
        bus.pos_x_flat = '0;
        bus.pos_y_flat = '0;
        for (int i = 0; i < 8; i++) begin
            cur_x[i] = 7'(10 + i);
            cur_y[i] = 6'(20 + i);
        end
        repeat (3) @(posedge clock);
        #1;
        chk("rst_to_scope", bus.to_scope, 0);
        chk("rst_active", bus.frame_active, 0);
        chk("rst_done", bus.frame_done, 0);
        reset = 1'b0;

        // No pos_valid: must stay idle.
        repeat (50) @(posedge clock);
        #1;

        // Basic frame.
        apply_and_push();
        wait_drain();

        // Mid-frame update must not tear the running frame.
        apply_and_push();
        wait_pos(10);
        for (int i = 0; i < 8; i++) cur_x[i] = 7'(40 + i);
        expect_gap1 = 1;
        apply_and_push();
        wait_drain();
        chk("gap_seen", expect_gap1 ? 1 : 0, 0);
        repeat (20) @(posedge clock);
        #1;

        // X clamp and Y maximum.
        cur_x[3] = 7'd127;
        cur_y[3] = 6'd63;
        apply_and_push();
        wait_drain();

        // Reset during object 4 X clears the frame and the pending flag.
        apply_and_push();
        wait_pos(10);
        pulse_valid();
        wait_pos(RST_POS);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort_to_scope", bus.to_scope, 0);
        chk("abort_active", bus.frame_active, 0);
        exp_q.delete();
        reset = 1'b0;
        repeat (60) @(posedge clock);
        #1;

        // Recovery after reset.
        apply_and_push();
        wait_drain();
        repeat (5) @(posedge clock);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scope_frame_serializer.md
Name: scope_frame_serializer

Overview:
- Downstream of the gravity simulator core. Consumes the 8 object positions and streams them to the 8-bit scope DAC port as timed frames.
- Each frame is a sync level followed by per-object X and Y levels, each held for a programmable dwell.
- Positions are snapshotted at frame start, so a frame is never torn by a mid-frame simulator update.

Parameters:
- DWELL, 1024: cycles each X/Y (and index) sample is held; legal range 1..65535.
- SYNC_DWELL, 4096: cycles the sync level is held at frame start; legal range 1..65535.
- FREE_RUN, 0: 1 means start a new frame whenever idle; 0 means start only when an update is pending.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pos_x_flat  in  56  object i X position at [7i+6:7i], unsigned, 0..127
- pos_y_flat  in  48  object i Y position at [6i+5:6i], unsigned, 0..63
- pos_valid  in  1  1-cycle strobe from the simulator: positions updated
- to_scope  out  8  registered scope sample
- frame_active  out  1  high while a frame is being emitted
- frame_done  out  1  1-cycle pulse on the last cycle of a frame's final Y sample

Behaviour:
- Reset:
  - to_scope = 8'h00, frame_active = 0, frame_done = 0.
  - State IDLE, pending = 0, obj_idx = 0, dwell counter = 0.
- Reset mid-frame aborts immediately; the next cycle shows the reset values.
- States and transitions:
  - IDLE -> SYNC -> [IDX] -> X -> Y.
  - After Y: go to [IDX]/X for the next object, or back to IDLE after object 7.
- pending:
  - Set by pos_valid in any state.
  - Cleared on the IDLE->SYNC transition.
  - If pos_valid coincides with that transition, pending stays set.
- Frame start:
  - Condition: in IDLE with (pending | FREE_RUN).
  - On that cycle all 104 position bits are latched into the snapshot, and the state moves to SYNC.
  - to_scope shows 8'h7F from the next cycle (1-cycle latency).
- Dwell timing:
  - SYNC holds 8'h7F for exactly SYNC_DWELL cycles.
  - X holds {1'b0, x_snap[obj_idx]} for exactly DWELL cycles. An X value of 127 is emitted as 8'h7E, so 8'h7F is reserved for sync.
  - Y holds {2'b00, y_snap[obj_idx]} for exactly DWELL cycles.
- Object order is 0..7. obj_idx increments on Y exit and wraps 7->0 on return to IDLE.
- frame_active:
  - High on every cycle to_scope carries frame data.
  - Low the cycle after the last Y sample.
- IDLE output:
  - to_scope = 8'h00 in IDLE.
  - With FREE_RUN=1 or pending set at frame end, IDLE lasts exactly 1 cycle of 8'h00 between frames.
- frame_done is asserted together with the last cycle of object 7's Y sample.
- pos_valid during a frame never changes the snapshot.
- Frame length, including the sync level: SYNC_DWELL + 8*2*DWELL cycles.
- Counters are sized to 16 bits; no overflow is possible within the legal parameter range.

Optional Feature:
- Macro: SCOPE_INDEX_EN.
- Defined:
  - Before each object's X, state IDX holds {5'b0, obj_idx} for DWELL cycles.
  - Frame length becomes SYNC_DWELL + 8*3*DWELL.
- Undefined:
  - IDX state and its logic are absent.
  - Sequence is SYNC, X, Y per object only.

Test Plan:
- Reset, then DWELL=2, SYNC_DWELL=3, FREE_RUN=0, no pos_valid for 50 cycles -> to_scope=0, frame_active=0 throughout.
- x[i]=10+i, y[i]=20+i, one pos_valid pulse:
  - 7F x3, then 0A x2, 14 x2, 0B x2, 15 x2 ... 11 x2, 1B x2.
  - frame_done on cycle 35 of the frame, then IDLE 00.
- Same positions; change pos_x_flat and pulse pos_valid mid-frame ->
  - Current frame is unchanged.
  - After 1 IDLE cycle a second frame starts with the new X values.
- x[3]=127, y[3]=63 -> object 3 emits 7E x2 then 3F x2. 7F appears only in SYNC.
- Assert reset during object 4's X sample -> next cycle to_scope=00, frame_active=0. No frame starts until a new pos_valid.
- SCOPE_INDEX_EN defined, DWELL=2, SYNC_DWELL=3 ->
  - Per object: 0i x2, X x2, Y x2.
  - Frame length is 51 cycles; frame_done is on cycle 51.
